// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the write-back register bank
// Purpose: register-file geometry plus a one-hot to index encoder.
// Ports: none (package).
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // OR-reduction encoder: exact only for one-hot inputs, which is the only case
  // where the result is used.
  function automatic logic [ADDR_W-1:0] onehot_to_idx(input logic [NREG-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (v[i]) idx = idx | ADDR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy scoreboard for in-flight destination registers
// Purpose: one busy flag per register, set at issue and cleared at write-back.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   iss_valid, iss_dest  issued instruction and its destination
//   clr_valid, clr_idx   legal write-back this cycle and its target
//   rs_addr, rt_addr     read port addresses
//   rs_busy, rt_busy     read targets a register still waiting on its producer
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  assign w_set = (iss_valid && (iss_dest != REG_ZERO)) ? (ONE << iss_dest) : '0;
  assign w_clr = clr_valid ? (ONE << clr_idx) : '0;

  // Set is applied after clear so a newer producer issued on the same edge
  // keeps the register pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  // A write landing this cycle is bypassed to the reader, so it hides the busy flag.
  assign rs_busy = (rs_addr != REG_ZERO) && r_busy[rs_addr] &&
                   !(clr_valid && (clr_idx == rs_addr));
  assign rt_busy = (rt_addr != REG_ZERO) && r_busy[rt_addr] &&
                   !(clr_valid && (clr_idx == rt_addr));

endmodule

// File: rtl/reg_bank_wb.sv
// rtl/reg_bank_wb.sv - write-back register bank with bypass, scoreboard and enable check
// Purpose: GPRs r1..r31 (r0 reads zero) written from a one-hot enable, two
//          combinational read ports with write-first bypass, RAW stall and a
//          sticky multi-hot enable error.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wb_valid/we/data     write-back beat, one-hot enable, data
//   iss_valid, iss_dest  issue of an instruction and its destination
//   rs_addr, rt_addr     read addresses
//   rs_data, rt_data     read data (combinational)
//   rs_busy, rt_busy     read target pending; stall = rs_busy | rt_busy
//   we_err               sticky multi-hot enable seen with wb_valid
module reg_bank_wb
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [NREG-1:0]   wb_we,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall,
  output logic              we_err
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_we_err;

  logic              w_multi;
  logic              w_legal_wr;
  logic [ADDR_W-1:0] w_wr_idx;

  // More than one bit set exactly when clearing the lowest set bit leaves something.
  assign w_multi    = |(wb_we & (wb_we - ONE));
  // Gating with rst_n keeps the bypass path quiet while reset is held.
  assign w_legal_wr = rst_n && wb_valid && (wb_we != '0) && !w_multi;
  assign w_wr_idx   = onehot_to_idx(wb_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_legal_wr && (w_wr_idx != REG_ZERO)) begin
      r_regs[w_wr_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_err <= 1'b0;
    end else if (wb_valid && w_multi) begin
      r_we_err <= 1'b1;
    end
  end

  assign we_err = r_we_err;

  assign rs_data = (rs_addr == REG_ZERO) ? '0 :
                   (w_legal_wr && (w_wr_idx == rs_addr)) ? wb_data : r_regs[rs_addr];
  assign rt_data = (rt_addr == REG_ZERO) ? '0 :
                   (w_legal_wr && (w_wr_idx == rt_addr)) ? wb_data : r_regs[rt_addr];

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .clr_valid (w_legal_wr),
    .clr_idx   (w_wr_idx),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy)
  );

  assign stall = rs_busy | rt_busy;

endmodule
